// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: mask, edge/level, pending latch, fixed priority, claim/EOI. Nesting via IRQ_CTRL_NEST_EN.
// Latency: src to HWInt is 2 cycles; register writes act at the write edge; Dout is combinational.
// Backpressure: none; every access completes in one cycle and a claim with no winner is a no-op.
module irq_ctrl #(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Addr,
    input  logic             WE,
    input  logic             RE,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    input  logic [N_SRC-1:0] src,
    output logic [N_SRC-1:0] HWInt
);

    localparam logic [1:0] A_MASK  = 2'd0;
    localparam logic [1:0] A_EDGE  = 2'd1;
    localparam logic [1:0] A_PEND  = 2'd2;
    localparam logic [1:0] A_CLAIM = 2'd3;
    localparam logic [3:0] N_SRC_W = 4'(N_SRC);

    logic [N_SRC-1:0] src_q, src_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] isr_q, isr_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] edge_q, edge_d;
    logic [N_SRC-1:0] hwint_q, hwint_d;

    logic [N_SRC-1:0] gate;
    logic [N_SRC-1:0] elig;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] claim_vec;
    logic [N_SRC-1:0] eoi_vec;
    logic             win_vld;
    logic [2:0]       win_id;
    logic             claim_hit;
    logic             eoi_hit;
    logic             unused_din;

`ifdef IRQ_CTRL_NEST_EN
    logic             isr_seen;

    // Only lines strictly above the highest-priority in-service line may interrupt it.
    always_comb begin
        gate     = '0;
        isr_seen = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            gate[i]  = ~isr_seen;
            isr_seen = isr_seen | isr_q[i];
        end
    end
`else
    always_comb begin
        gate = {N_SRC{isr_q == '0}};
    end
`endif

    always_comb begin
        elig    = pend_q & mask_q & ~isr_q & gate;
        win_vld = 1'b0;
        win_id  = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_vld = 1'b1;
                win_id  = 3'(i);
            end
        end
    end

    always_comb begin
        claim_hit = RE & ~WE & (Addr == A_CLAIM) & win_vld;
        eoi_hit   = WE & (Addr == A_CLAIM) & ({1'b0, Din[2:0]} < N_SRC_W);
        rise      = src & ~src_q;
        w1c       = (WE && Addr == A_PEND) ? Din[N_SRC-1:0] : '0;
        claim_vec = '0;
        eoi_vec   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            claim_vec[i] = claim_hit && (win_id == 3'(i));
            eoi_vec[i]   = eoi_hit && (Din[2:0] == 3'(i));
        end
    end

    // A new edge beats a same-cycle clear; level lines simply follow the pin.
    always_comb begin
        src_d   = src;
        pend_d  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            pend_d[i] = edge_q[i] ? (rise[i] | (pend_q[i] & ~(w1c[i] | claim_vec[i])))
                                  : src[i];
        end
        isr_d   = (isr_q | claim_vec) & ~eoi_vec;
        mask_d  = (WE && Addr == A_MASK) ? Din[N_SRC-1:0] : mask_q;
        edge_d  = (WE && Addr == A_EDGE) ? Din[N_SRC-1:0] : edge_q;
        hwint_d = elig;
    end

    always_comb begin
        Dout = '0;
        case (Addr)
            A_MASK:  Dout[N_SRC-1:0] = mask_q;
            A_EDGE:  Dout[N_SRC-1:0] = edge_q;
            A_PEND:  Dout[N_SRC-1:0] = pend_q;
            default: begin
                Dout[31]  = win_vld;
                Dout[2:0] = win_id;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q   <= '0;
            pend_q  <= '0;
            isr_q   <= '0;
            mask_q  <= '0;
            edge_q  <= '0;
            hwint_q <= '0;
        end else begin
            src_q   <= src_d;
            pend_q  <= pend_d;
            isr_q   <= isr_d;
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            hwint_q <= hwint_d;
        end
    end

    assign HWInt      = hwint_q;
    assign unused_din = ^Din;

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomised and directed bench for irq_ctrl against a per-line behavioural model.
module tb_irq_ctrl;

    localparam int N = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   Addr;
    logic         WE;
    logic         RE;
    logic [31:0]  Din;
    logic [31:0]  Dout;
    logic [N-1:0] src;
    logic [N-1:0] HWInt;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: one bit per line, updated from the register-map rules.
    bit m_mask [N];
    bit m_edge [N];
    bit m_pend [N];
    bit m_isr  [N];
    bit m_prev [N];
    bit m_hw   [N];

    irq_ctrl #(.N_SRC(N)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .RE    (RE),
        .Din   (Din),
        .Dout  (Dout),
        .src   (src),
        .HWInt (HWInt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit any_isr();
        for (int i = 0; i < N; i++) if (m_isr[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit gated(input int i);
`ifdef IRQ_CTRL_NEST_EN
        for (int j = 0; j <= i; j++) if (m_isr[j]) return 1'b0;
        return 1'b1;
`else
        return !any_isr();
`endif
    endfunction

    function automatic bit eligible(input int i);
        return m_pend[i] && m_mask[i] && !m_isr[i] && gated(i);
    endfunction

    function automatic int winner();
        for (int i = 0; i < N; i++) if (eligible(i)) return i;
        return -1;
    endfunction

    function automatic logic [31:0] vec(input bit v [N]);
        logic [31:0] r = 0;
        for (int i = 0; i < N; i++) if (v[i]) r += (32'd1 << i);
        return r;
    endfunction

    function automatic logic [31:0] m_dout(input logic [1:0] a);
        int w = winner();
        case (a)
            2'd0: return vec(m_mask);
            2'd1: return vec(m_edge);
            2'd2: return vec(m_pend);
            default: return (w < 0) ? 32'd0 : (32'h8000_0000 + w);
        endcase
    endfunction

    function automatic logic [31:0] m_hwint();
        return vec(m_hw);
    endfunction

    task automatic m_step();
        int  w;
        bit  claim;
        bit  new_pend [N];
        bit  new_hw   [N];
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_mask[i] = 0; m_edge[i] = 0; m_pend[i] = 0;
                m_isr[i]  = 0; m_prev[i] = 0; m_hw[i]   = 0;
            end
            return;
        end
        w     = winner();
        claim = RE && !WE && Addr == 2'd3 && w >= 0;
        for (int i = 0; i < N; i++) begin
            new_hw[i] = eligible(i);
            if (m_edge[i]) begin
                bit cleared = (WE && Addr == 2'd2 && Din[i]) || (claim && w == i);
                new_pend[i] = (src[i] && !m_prev[i]) || (m_pend[i] && !cleared);
            end else begin
                new_pend[i] = src[i];
            end
        end
        if (claim) m_isr[w] = 1;
        if (WE && Addr == 2'd3 && int'(Din[2:0]) < N) m_isr[int'(Din[2:0])] = 0;
        for (int i = 0; i < N; i++) begin
            if (WE && Addr == 2'd0) m_mask[i] = Din[i];
            if (WE && Addr == 2'd1) m_edge[i] = Din[i];
            m_pend[i] = new_pend[i];
            m_hw[i]   = new_hw[i];
            m_prev[i] = src[i];
        end
    endtask

    // One clock: drive inputs, compare outputs against the model, advance both.
    task automatic cyc(input logic [1:0] a, input logic we, input logic re,
                       input logic [31:0] din, input logic [N-1:0] s);
        Addr = a; WE = we; RE = re; Din = din; src = s;
        #1;
        check("hwint", {26'd0, HWInt}, m_hwint());
        check("dout", Dout, m_dout(a));
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        Addr = a; WE = 1'b0; RE = 1'b0;
        #1;
        check(tag, Dout, exp);
    endtask

    initial begin
        reset = 1'b1; Addr = 0; WE = 0; RE = 0; Din = 0; src = 0;
        for (int i = 0; i < N; i++) begin
            m_mask[i] = 0; m_edge[i] = 0; m_pend[i] = 0;
            m_isr[i]  = 0; m_prev[i] = 0; m_hw[i]   = 0;
        end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        reset = 1'b0;

        // Reset with lines active and MASK programmed.
        cyc(0, 1, 0, 32'h3F, 0);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 6'h3F);
        cyc(0, 0, 0, 0, 6'h3F);
        reset = 1'b0;
        check("rst_hwint", {26'd0, HWInt}, 32'd0);
        rd(0, 32'd0, "rst_mask");
        rd(1, 32'd0, "rst_edge");
        rd(2, 32'd0, "rst_pend");
        rd(3, 32'd0, "rst_claim");
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Edge latch and claim.
        cyc(0, 1, 0, 32'h3F, 0);
        cyc(1, 1, 0, 32'h03, 0);
        cyc(0, 0, 0, 0, 6'h02);
        cyc(0, 0, 0, 0, 6'h00);
        check("edge_hwint", {26'd0, HWInt}, 32'h02);
        cyc(0, 0, 0, 0, 6'h00);
        check("edge_held", {26'd0, HWInt}, 32'h02);
        rd(3, 32'h8000_0001, "edge_claim");
        cyc(3, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("edge_claimed", {26'd0, HWInt}, 32'd0);
        cyc(3, 1, 0, 32'd1, 0);
        cyc(0, 0, 0, 0, 0);
        check("edge_eoi", {26'd0, HWInt}, 32'd0);

        // Priority between level lines 2 and 4.
        cyc(0, 0, 0, 0, 6'h14);
        cyc(0, 0, 0, 0, 6'h14);
        check("prio_hwint", {26'd0, HWInt}, 32'h14);
        rd(3, 32'h8000_0002, "prio_claim");
        cyc(3, 0, 1, 0, 6'h10);
        cyc(0, 0, 0, 0, 6'h10);
        check("prio_inserv", {26'd0, HWInt}, 32'd0);
        cyc(3, 1, 0, 32'd2, 6'h10);
        cyc(0, 0, 0, 0, 6'h10);
        check("prio_eoi", {26'd0, HWInt}, 32'h10);

        // Line 4 in service, then an edge on line 0.
        rd(3, 32'h8000_0004, "nest_claim4");
        cyc(3, 0, 1, 0, 6'h10);
        cyc(0, 0, 0, 0, 6'h10);
        check("nest_c4_hwint", {26'd0, HWInt}, 32'd0);
        cyc(0, 0, 0, 0, 6'h11);
        cyc(0, 0, 0, 0, 6'h10);
`ifdef IRQ_CTRL_NEST_EN
        check("nest_preempt", {26'd0, HWInt}, 32'h01);
        rd(3, 32'h8000_0000, "nest_claim0");
        cyc(3, 0, 1, 0, 6'h10);
        cyc(0, 0, 0, 0, 6'h10);
        check("nest_both_isr", {26'd0, HWInt}, 32'd0);
        cyc(3, 1, 0, 32'd0, 6'h10);
        cyc(3, 1, 0, 32'd4, 6'h00);
        cyc(0, 0, 0, 0, 0);
        check("nest_done", {26'd0, HWInt}, 32'd0);
        rd(3, 32'd0, "nest_idle_claim");
`else
        check("nonest_block", {26'd0, HWInt}, 32'd0);
        cyc(0, 0, 0, 0, 6'h10);
        check("nonest_hold", {26'd0, HWInt}, 32'd0);
        rd(3, 32'd0, "nonest_claim");
        cyc(3, 1, 0, 32'd4, 6'h00);
        cyc(0, 0, 0, 0, 0);
        check("nonest_after_eoi", {26'd0, HWInt}, 32'h01);
        rd(3, 32'h8000_0000, "nonest_claim0");
        cyc(3, 0, 1, 0, 0);
        cyc(3, 1, 0, 32'd0, 0);
        cyc(0, 0, 0, 0, 0);
`endif

        // Edge and W1C on line 3 together; EOI with out-of-range id.
        cyc(1, 1, 0, 32'h0F, 0);
        cyc(2, 1, 0, 32'h08, 6'h08);
        rd(2, 32'h08, "w1c_edge_wins");
        cyc(3, 1, 0, 32'd7, 6'h08);
        check("eoi7_hwint", {26'd0, HWInt}, 32'h08);
        rd(2, 32'h08, "eoi7_pend");
        rd(3, 32'h8000_0003, "eoi7_claim");
        cyc(2, 1, 0, 32'h08, 6'h08);
        rd(2, 32'd0, "w1c_clear");
        cyc(0, 0, 0, 0, 0);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            logic [1:0]   a;
            logic         we, re;
            logic [31:0]  d;
            logic [N-1:0] s;
            reset = ($urandom_range(0, 199) == 0);
            a  = 2'($urandom_range(0, 3));
            we = ($urandom_range(0, 5) == 0);
            re = ($urandom_range(0, 3) == 0);
            d  = $urandom;
            s  = ($urandom_range(0, 2) == 0) ? N'($urandom) : src;
            cyc(a, we, re, d, s);
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
